strobe_arb: RTL and testbench



---
 rtl/strobe_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 43 ++++
 rtl/strobe_arb.sv | 126 ++++++++++++
 tb/tb_strobe_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_arb_pkg.sv
// strobe_arb_pkg
// Shared types and limits for the strobe arbiter and the clock-control
// arbiters that reuse its round-robin picker.
//   strobe_arb_state_t  : sequencer states (idle, strobe, stretch, gap)
//   STROBE_ARB_MAX_NREQ : largest supported requester count
package strobe_arb_pkg;

    localparam int STROBE_ARB_MAX_NREQ = 8;

    // The stretch state only gets used when STROBE_ARB_STRETCH_EN is defined,
    // but it keeps its encoding so every build shares one state type.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STROBE  = 2'd1,
        S_STRETCH = 2'd2,
        S_GAP     = 2'd3
    } strobe_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. It searches req upward starting one
// above ptr, wrapping modulo NREQ, and reports the first set bit. The
// requester at ptr itself is checked last, so the previous winner has the
// lowest priority.
//   req   in  NREQ   request vector
//   ptr   in  PW     index of the previous winner
//   found out 1      any request present
//   idx   out PW     index of the winning requester (holds ptr if none)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    logic [PW:0]   sum;
    logic [PW-1:0] pos;

    // The loop runs from the farthest candidate to the nearest. The last
    // match written is therefore the nearest set bit above ptr.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        sum   = '0;
        pos   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            pos = sum[PW-1:0];
            if (req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/strobe_arb.sv
// strobe_arb
// Round-robin arbiter and sequencer that shares one strobe line among NREQ
// requesters. Each grant drives the strobe for max(len,1) cycles. When
// STROBE_ARB_STRETCH_EN is defined, one trailing stretch cycle follows. After
// the strobe come GAP dead cycles, then a single idle arbitration cycle.
//   clk     in  1      system clock
//   rst_n   in  1      asynchronous active-low reset
//   req     in  NREQ   level requests, held until done
//   len     in  LENW   strobe length, sampled at grant (0 means 1)
//   gnt     out NREQ   one-hot grant for the strobe (and stretch) duration
//   owner   out PW     current or most recent grantee
//   strobe  out 1      shared strobe
//   busy    out 1      high whenever the sequencer is not idle
//   done    out NREQ   one-cycle pulse to the owner after its last strobe cycle
module strobe_arb
    import strobe_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LENW = 3,
    parameter int GAP  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [LENW-1:0]         len,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    strobe,
    output logic                    busy,
    output logic [NREQ-1:0]         done
);

    localparam int PW = $clog2(NREQ);
    localparam logic [2:0] GAP_INIT = 3'(GAP);
    localparam strobe_arb_state_t POST_STATE = (GAP > 0) ? S_GAP : S_IDLE;

    strobe_arb_state_t state;
    logic [LENW-1:0]   cnt;
    logic [2:0]        gap_cnt;
    logic [PW-1:0]     ptr;
    logic              pick_found;
    logic [PW-1:0]     pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Leaving the final strobe cycle clears gnt and strobe. It also echoes
    // the one-hot gnt onto done, so the pulse lands in the first cycle after
    // the strobe, whether that cycle is a gap cycle or the idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            ptr     <= PW'(NREQ-1);
            gnt     <= '0;
            owner   <= '0;
            strobe  <= 1'b0;
            busy    <= 1'b0;
            done    <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        state  <= S_STROBE;
                        cnt    <= (len == '0) ? LENW'(1) : len;
                        gnt    <= NREQ'(1) << pick_idx;
                        owner  <= pick_idx;
                        ptr    <= pick_idx;
                        strobe <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt == LENW'(1)) begin
`ifdef STROBE_ARB_STRETCH_EN
                        state   <= S_STRETCH;
`else
                        state   <= POST_STATE;
                        strobe  <= 1'b0;
                        gnt     <= '0;
                        done    <= gnt;
                        busy    <= (GAP > 0);
                        gap_cnt <= GAP_INIT;
`endif
                    end else begin
                        cnt <= cnt - LENW'(1);
                    end
                end
`ifdef STROBE_ARB_STRETCH_EN
                S_STRETCH: begin
                    state   <= POST_STATE;
                    strobe  <= 1'b0;
                    gnt     <= '0;
                    done    <= gnt;
                    busy    <= (GAP > 0);
                    gap_cnt <= GAP_INIT;
                end
`endif
                S_GAP: begin
                    if (gap_cnt <= 3'd1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    strobe <= 1'b0;
                    gnt    <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_arb.sv
// tb_strobe_arb
// Bench for strobe_arb. The main instance uses GAP=1 and is checked by a
// queue-based scoreboard. A second instance uses GAP=0 and is exercised with
// back-to-back requests.
module tb_strobe_arb;

    localparam int NREQ = 4;
    localparam int LENW = 3;
    localparam int GAP  = 1;
`ifdef STROBE_ARB_STRETCH_EN
    localparam int STR = 1;
`else
    localparam int STR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [2:0] len = '0;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       strobe;
    logic       busy;
    logic [3:0] done;

    logic [3:0] req0 = '0;
    logic [2:0] len0 = '0;
    logic [3:0] gnt0;
    logic [1:0] owner0;
    logic       strobe0;
    logic       busy0;
    logic [3:0] done0;

    always #5 clk = ~clk;

    strobe_arb #(.NREQ(NREQ), .LENW(LENW), .GAP(GAP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .len    (len),
        .gnt    (gnt),
        .owner  (owner),
        .strobe (strobe),
        .busy   (busy),
        .done   (done)
    );

    strobe_arb #(.NREQ(NREQ), .LENW(LENW), .GAP(0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req0),
        .len    (len0),
        .gnt    (gnt0),
        .owner  (owner0),
        .strobe (strobe0),
        .busy   (busy0),
        .done   (done0)
    );

    typedef struct {
        logic [3:0] req;
        logic [2:0] len;
        int         idx;
        int         lbase;
    } vec_t;

    typedef struct {
        int idx;
        int len;
    } exp_t;

    exp_t sb[$];
    int   rise_cycle[$];
    int   checks = 0;
    int   errors = 0;

    bit   active = 1'b0;
    exp_t cur;
    int   run = 0;
    int   last_owner = 0;
    int   cycle = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic nextSample();
        @(negedge clk);
        #1;
    endtask

    // The scoreboard pops an expectation at each strobe rise. It checks the
    // strobe length, the timing of done, and that owner holds while idle.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            active     = 1'b0;
            last_owner = 0;
        end else begin
            if (gnt != '0) checkOutput("gnt_onehot", int'($onehot(gnt)), 1);
            if (strobe) checkOutput("strobe_has_gnt", int'(gnt != '0), 1);
            if (strobe && !active) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_pending", sb.size(), 1);
                    cur = '{-1, 0};
                end else begin
                    cur = sb.pop_front();
                end
                active = 1'b1;
                run    = 1;
                rise_cycle.push_back(cycle);
                checkOutput("gnt_at_rise", int'(gnt), 1 << cur.idx);
                checkOutput("owner_at_rise", int'(owner), cur.idx);
                checkOutput("busy_at_rise", int'(busy), 1);
                last_owner = cur.idx;
            end else if (strobe) begin
                run++;
                checkOutput("gnt_hold", int'(gnt), 1 << cur.idx);
            end else if (active) begin
                active = 1'b0;
                checkOutput("strobe_len", run, cur.len);
                checkOutput("done_pulse", int'(done), 1 << cur.idx);
                checkOutput("gnt_after", int'(gnt), 0);
            end else begin
                if (done != '0) checkOutput("stray_done", int'(done), 0);
                checkOutput("owner_hold", int'(owner), last_owner);
            end
        end
    end

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            nextSample();
            if (!busy && !active && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("idle_reached", int'(ok), 1);
        if (!ok) sb.delete();
    endtask

    task automatic applyStimulus(input vec_t v);
        bit seen;
        waitIdle();
        req = v.req;
        len = v.len;
        sb.push_back('{v.idx, v.lbase + STR});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nextSample();
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("grant_seen", int'(seen), 1);
        len  = 3'($urandom);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done != '0) begin
                seen = 1'b1;
                break;
            end
            nextSample();
        end
        checkOutput("done_seen", int'(seen), 1);
        req = '0;
        nextSample();
        checkOutput("busy_after_done", int'(busy), 0);
    endtask

    vec_t tbl[8];
    int   exp_g[4];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit   seen;
        bit   prev_s;
        int   rises;
        int   low_run;
        int   run_len;
        int   prev_gnt;

        // Winners follow from the pointer, which starts at 3 and moves to each winner.
        tbl[0] = '{4'b0001, 3'd3, 0, 3};
        tbl[1] = '{4'b1111, 3'd1, 1, 1};
        tbl[2] = '{4'b1001, 3'd0, 3, 1};
        tbl[3] = '{4'b0110, 3'd7, 1, 7};
        tbl[4] = '{4'b0101, 3'd2, 2, 2};
        tbl[5] = '{4'b0011, 3'd5, 0, 5};
        tbl[6] = '{4'b1000, 3'd4, 3, 4};
        tbl[7] = '{4'b0100, 3'd6, 2, 6};
        exp_g  = '{1, 2, 1, 2};

        $display("[TB] reset values");
        #12;
        checkOutput("rst_gnt", int'(gnt), 0);
        checkOutput("rst_owner", int'(owner), 0);
        checkOutput("rst_strobe", int'(strobe), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_strobe0", int'(strobe0), 0);
        nextSample();
        rst_n = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

        $display("[TB] reset in second strobe cycle");
        waitIdle();
        req = 4'b0100;
        len = 3'd5;
        sb.push_back('{2, 5 + STR});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nextSample();
            if (strobe) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("abort_grant_seen", int'(seen), 1);
        @(posedge clk);
        #2;
        checkOutput("abort_strobe_before", int'(strobe), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_strobe", int'(strobe), 0);
        checkOutput("abort_gnt", int'(gnt), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        sb.delete();
        req = '0;
        nextSample();
        nextSample();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nextSample();
            checkOutput("abort_no_done", int'(done), 0);
        end

        $display("[TB] rotation after reset");
        rise_cycle.delete();
        req = 4'b1111;
        len = 3'd1;
        for (int i = 0; i < 5; i++) sb.push_back('{i % 4, 1 + STR});
        for (int k = 0; k < 100; k++) begin
            nextSample();
            if (rise_cycle.size() >= 5) break;
        end
        req = '0;
        waitIdle();
        checkOutput("rr_grants", rise_cycle.size(), 5);
        for (int i = 1; i < rise_cycle.size(); i++) begin
            checkOutput("rr_period", rise_cycle[i] - rise_cycle[i-1], 1 + STR + GAP + 1);
        end

        $display("[TB] request dropped mid-grant");
        req = 4'b0100;
        len = 3'd5;
        sb.push_back('{2, 5 + STR});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nextSample();
            if (strobe) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("drop_grant_seen", int'(seen), 1);
        nextSample();
        req  = '0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            nextSample();
            if (done != '0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("drop_done_seen", int'(seen), 1);
        waitIdle();

        $display("[TB] back-to-back with zero gap");
        req0     = 4'b0011;
        len0     = 3'd2;
        prev_s   = 1'b0;
        rises    = 0;
        low_run  = 0;
        run_len  = 0;
        prev_gnt = 0;
        for (int k = 0; k < 40; k++) begin
            nextSample();
            checkOutput("gap0_onehot", int'($countones(gnt0) <= 1), 1);
            if (strobe0 && !prev_s) begin
                rises++;
                if (rises <= 4) checkOutput("gap0_grant", int'(gnt0), exp_g[rises-1]);
                if (rises > 1) checkOutput("gap0_low_run", low_run, 1);
                low_run  = 0;
                run_len  = 1;
                prev_gnt = int'(gnt0);
            end else if (strobe0) begin
                run_len++;
            end else if (prev_s) begin
                checkOutput("gap0_len", run_len, 2 + STR);
                checkOutput("gap0_done", int'(done0), prev_gnt);
                checkOutput("gap0_busy_low", int'(busy0), 0);
                low_run = 1;
            end else if (rises > 0) begin
                low_run++;
            end
            prev_s = strobe0;
        end
        checkOutput("gap0_enough_rises", int'(rises >= 4), 1);
        req0 = '0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nextSample();
            if (!busy0) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("gap0_idle", int'(seen), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
